exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
- Writeback-stage exception/ERET commit controller; drives the CP0 register file's exception-side inputs: wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr, eret_flush.
- Consumes has_int and c0_epc from CP0.
- Picks the single highest-priority event for the WB instruction and reports it to CP0 for exactly one cycle.
- Sequences a pipeline flush, then a fetch redirect (to the exception vector or EPC) with a valid/ready handshake.

Parameters:
- EXC_VEC, 32'hbfc00380: exception entry PC (BEV=1).
- FLUSH_MIN_CYC, 2: minimum cycles spent in DRAIN; legal range >=1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ws_valid  in  1  WB stage holds a valid instruction
- ws_pc  in  32  PC of WB instruction
- ws_bd  in  1  WB instruction is in a delay slot
- ws_adel_if  in  1  fetch address error
- ws_ri  in  1  reserved instruction
- ws_ov  in  1  overflow
- ws_sys  in  1  syscall
- ws_bp  in  1  break
- ws_adel_ld  in  1  load address error
- ws_ades_st  in  1  store address error
- ws_data_addr  in  32  load/store effective address
- ws_eret  in  1  WB instruction is ERET
- has_int  in  1  CP0 pending, enabled interrupt
- c0_epc  in  32  CP0 EPC
- redirect_ready  in  1  fetch accepts redirect
- ws_ready_go  out  1  WB may retire; 0 while not IDLE
- wb_ex  out  1  one-cycle exception pulse to CP0
- wb_excode  out  5  exception code
- wb_bd  out  1  delay-slot flag
- wb_pc  out  32  raw PC (CP0 applies the BD adjustment)
- wb_badvaddr  out  32  faulting address
- eret_flush  out  1  one-cycle ERET pulse to CP0
- flush  out  1  discard all in-flight instructions
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0 except ws_ready_go=1. Reset mid-DRAIN/REDIRECT aborts immediately; no pulse is replayed.
- Priority, highest first, evaluated only when ws_valid && IDLE:
  - has_int: excode 0x00
  - ws_adel_if: 0x04, badvaddr=ws_pc
  - ws_ri: 0x0a
  - ws_ov: 0x0c
  - ws_sys: 0x08
  - ws_bp: 0x09
  - ws_adel_ld: 0x04, badvaddr=ws_data_addr
  - ws_ades_st: 0x05, badvaddr=ws_data_addr
  - ws_eret (only when no exception is present)
  - For excodes without a bad address, wb_badvaddr=0.
- Accept cycle T, all outputs registered:
  - T+1: wb_ex (or eret_flush) =1 for exactly one cycle, with wb_excode/wb_bd/wb_pc/wb_badvaddr; flush=1; ws_ready_go=0; state=DRAIN, counter loaded FLUSH_MIN_CYC-1.
  - ws_ready_go is combinational: (state==IDLE) && !event, so the faulting instruction does not retire.
- DRAIN:
  - flush=1; counter decrements each cycle.
  - At 0: state=REDIRECT; redirect_valid=1; redirect_pc = EXC_VEC for an exception, or c0_epc sampled on that DRAIN-to-REDIRECT edge for ERET.
- REDIRECT:
  - flush=1; redirect_valid and redirect_pc held stable until redirect_ready.
  - Handshake cycle: next cycle state=IDLE, flush=0, redirect_valid=0.
- Ignored inputs: all ws_* inputs and has_int are ignored outside IDLE; younger instructions never produce pulses.
- Simultaneous events:
  - eret + any exception: exception wins, no eret_flush.
  - has_int + eret: interrupt wins.
  - redirect_ready high before REDIRECT: no effect.
- With no valid instruction: ws_valid=0 means nothing is taken, even if has_int=1; the interrupt waits for the next valid instruction.
- Invariant: wb_ex and eret_flush are never high in the same cycle.

Decomposition:
- Shared package/header:
  - EX_* codes: INT, ADEL, ADES, SYS, BP, RI, OV
  - state encodings: IDLE, DRAIN, REDIRECT
  - default EXC_VEC
- Sub-module exc_prio_enc (combinational): flag vector plus has_int in -> {event, is_ex, is_eret, excode, badvaddr_sel} out. FSM, counter and output registers stay in the top.

Test Plan:
- Reset, then ws_valid=1, ws_ov=1, ws_pc=0xbfc00100 -> T+1: wb_ex=1, wb_excode=0x0c, wb_pc=0xbfc00100; flush high ≥2 cycles; then redirect_valid=1, redirect_pc=0xbfc00380; redirect_ready=1 -> IDLE next cycle.
- ws_adel_ld=1, ws_ri=1, ws_data_addr=0x1003 -> excode 0x0a, badvaddr 0; repeat with ws_adel_ld only -> excode 0x04, badvaddr 0x00001003; ws_adel_if=1, ws_pc=0xbfc00002 -> badvaddr 0xbfc00002.
- ws_eret=1, c0_epc=0xbfc01234 -> eret_flush one cycle, wb_ex=0, redirect_pc=0xbfc01234; ws_eret+ws_sys -> wb_ex, excode 0x08, no eret_flush.
- has_int=1, ws_valid=0 for 3 cycles -> no pulse; then ws_valid=1, ws_bd=1 -> excode 0x00, wb_bd=1; new ws_valid+ws_bp during DRAIN/REDIRECT -> ignored, ws_ready_go=0.
- redirect_ready held 0 for 10 cycles -> redirect_valid/redirect_pc stable, flush stays 1; async reset asserted mid-REDIRECT -> all outputs 0 immediately, ws_ready_go=1.

Source files
------------

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared types and constants for the writeback exception/ERET commit controller.
// Exception codes follow the MIPS CP0 Cause.ExcCode encoding.
package exc_commit_ctrl_pkg;

   localparam logic [31:0] EXC_VEC_DEFAULT = 32'hbfc00380;

   localparam logic [4:0] EX_INT  = 5'h00;
   localparam logic [4:0] EX_ADEL = 5'h04;
   localparam logic [4:0] EX_ADES = 5'h05;
   localparam logic [4:0] EX_SYS  = 5'h08;
   localparam logic [4:0] EX_BP   = 5'h09;
   localparam logic [4:0] EX_RI   = 5'h0a;
   localparam logic [4:0] EX_OV   = 5'h0c;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BV_NONE = 2'd0,
      BV_PC   = 2'd1,
      BV_DATA = 2'd2
   } bv_sel_e;

   // Per-instruction event flags, listed in decreasing exception priority.
   typedef struct packed {
      logic adel_if;
      logic ri;
      logic ov;
      logic sys;
      logic bp;
      logic adel_ld;
      logic ades_st;
      logic eret;
   } ws_flags_t;

endpackage

// File: rtl/exc_commit_ctrl_prio.sv
// Priority encoder: picks the single winning event for the WB instruction.
// Purely combinational; qualification with ws_valid and FSM state happens in the top.
module exc_prio_enc
   import exc_commit_ctrl_pkg::*;
(
   input  logic      has_int,
   input  ws_flags_t flags,
   output logic      evt,
   output logic      is_ex,
   output logic      is_eret,
   output logic [4:0] excode,
   output bv_sel_e   badvaddr_sel
);

   always_comb begin
      is_ex        = 1'b1;
      excode       = EX_INT;
      badvaddr_sel = BV_NONE;
      if (has_int) begin
         excode = EX_INT;
      end else if (flags.adel_if) begin
         excode       = EX_ADEL;
         badvaddr_sel = BV_PC;
      end else if (flags.ri) begin
         excode = EX_RI;
      end else if (flags.ov) begin
         excode = EX_OV;
      end else if (flags.sys) begin
         excode = EX_SYS;
      end else if (flags.bp) begin
         excode = EX_BP;
      end else if (flags.adel_ld) begin
         excode       = EX_ADEL;
         badvaddr_sel = BV_DATA;
      end else if (flags.ades_st) begin
         excode       = EX_ADES;
         badvaddr_sel = BV_DATA;
      end else begin
         is_ex = 1'b0;
      end
      // ERET only commits when nothing else fires on the same instruction.
      is_eret = !is_ex && flags.eret;
      evt     = is_ex || is_eret;
   end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback exception/ERET commit controller: one-cycle CP0 report, flush drain,
// then a valid/ready fetch redirect to the exception vector or EPC.
module exc_commit_ctrl
   import exc_commit_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VEC       = EXC_VEC_DEFAULT,
   parameter int unsigned FLUSH_MIN_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ws_valid,
   input  logic [31:0] ws_pc,
   input  logic        ws_bd,
   input  logic        ws_adel_if,
   input  logic        ws_ri,
   input  logic        ws_ov,
   input  logic        ws_sys,
   input  logic        ws_bp,
   input  logic        ws_adel_ld,
   input  logic        ws_ades_st,
   input  logic [31:0] ws_data_addr,
   input  logic        ws_eret,
   input  logic        has_int,
   input  logic [31:0] c0_epc,
   input  logic        redirect_ready,
   output logic        ws_ready_go,
   output logic        wb_ex,
   output logic [4:0]  wb_excode,
   output logic        wb_bd,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_badvaddr,
   output logic        eret_flush,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int CNT_W = (FLUSH_MIN_CYC > 1) ? $clog2(FLUSH_MIN_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_MIN_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             kind_ex_q, kind_ex_d;
   logic             wb_ex_q, wb_ex_d;
   logic             eret_flush_q, eret_flush_d;
   logic [4:0]       wb_excode_q, wb_excode_d;
   logic             wb_bd_q, wb_bd_d;
   logic [31:0]      wb_pc_q, wb_pc_d;
   logic [31:0]      wb_badvaddr_q, wb_badvaddr_d;
   logic             flush_q, flush_d;
   logic             redirect_valid_q, redirect_valid_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;

   ws_flags_t flags;
   logic      enc_evt, enc_is_ex, enc_is_eret;
   logic [4:0] enc_excode;
   bv_sel_e   enc_bv_sel;
   logic      take;

   assign flags = '{adel_if: ws_adel_if, ri: ws_ri, ov: ws_ov, sys: ws_sys, bp: ws_bp,
                    adel_ld: ws_adel_ld, ades_st: ws_ades_st, eret: ws_eret};

   exc_prio_enc u_prio (
      .has_int      (has_int),
      .flags        (flags),
      .evt          (enc_evt),
      .is_ex        (enc_is_ex),
      .is_eret      (enc_is_eret),
      .excode       (enc_excode),
      .badvaddr_sel (enc_bv_sel)
   );

   assign take        = (state_q == ST_IDLE) && ws_valid && enc_evt;
   // Combinational so the faulting instruction never retires in its accept cycle.
   assign ws_ready_go = (state_q == ST_IDLE) && !(ws_valid && enc_evt);

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      kind_ex_d        = kind_ex_q;
      wb_ex_d          = 1'b0;
      eret_flush_d     = 1'b0;
      wb_excode_d      = '0;
      wb_bd_d          = 1'b0;
      wb_pc_d          = '0;
      wb_badvaddr_d    = '0;
      flush_d          = flush_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (take) begin
               wb_ex_d      = enc_is_ex;
               eret_flush_d = enc_is_eret;
               kind_ex_d    = enc_is_ex;
               flush_d      = 1'b1;
               cnt_d        = CNT_LOAD;
               state_d      = ST_DRAIN;
               if (enc_is_ex) begin
                  wb_excode_d = enc_excode;
                  wb_bd_d     = ws_bd;
                  wb_pc_d     = ws_pc;
                  unique case (enc_bv_sel)
                     BV_PC:   wb_badvaddr_d = ws_pc;
                     BV_DATA: wb_badvaddr_d = ws_data_addr;
                     default: wb_badvaddr_d = '0;
                  endcase
               end
            end
         end
         ST_DRAIN: begin
            flush_d = 1'b1;
            if (cnt_q == '0) begin
               state_d          = ST_REDIRECT;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = kind_ex_q ? EXC_VEC : c0_epc;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_REDIRECT: begin
            flush_d = 1'b1;
            if (redirect_ready) begin
               state_d          = ST_IDLE;
               flush_d          = 1'b0;
               redirect_valid_d = 1'b0;
               redirect_pc_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         kind_ex_q        <= 1'b0;
         wb_ex_q          <= 1'b0;
         eret_flush_q     <= 1'b0;
         wb_excode_q      <= '0;
         wb_bd_q          <= 1'b0;
         wb_pc_q          <= '0;
         wb_badvaddr_q    <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         kind_ex_q        <= kind_ex_d;
         wb_ex_q          <= wb_ex_d;
         eret_flush_q     <= eret_flush_d;
         wb_excode_q      <= wb_excode_d;
         wb_bd_q          <= wb_bd_d;
         wb_pc_q          <= wb_pc_d;
         wb_badvaddr_q    <= wb_badvaddr_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign wb_ex          = wb_ex_q;
   assign eret_flush     = eret_flush_q;
   assign wb_excode      = wb_excode_q;
   assign wb_bd          = wb_bd_q;
   assign wb_pc          = wb_pc_q;
   assign wb_badvaddr    = wb_badvaddr_q;
   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: expected commit records are queued when
// an event is driven and popped when the CP0 pulse appears.
module tb_exc_commit_ctrl;

   localparam logic [31:0] VEC = 32'hbfc00380;

   typedef struct packed {
      logic        ex;
      logic        eret;
      logic [4:0]  excode;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] bva;
      logic [31:0] rpc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_valid, ws_bd, ws_adel_if, ws_ri, ws_ov, ws_sys, ws_bp;
   logic        ws_adel_ld, ws_ades_st, ws_eret, has_int, redirect_ready;
   logic [31:0] ws_pc, ws_data_addr, c0_epc;
   logic        ws_ready_go, wb_ex, wb_bd, eret_flush, flush, redirect_valid;
   logic [4:0]  wb_excode;
   logic [31:0] wb_pc, wb_badvaddr, redirect_pc;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   exc_commit_ctrl dut (
      .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd),
      .ws_adel_if(ws_adel_if), .ws_ri(ws_ri), .ws_ov(ws_ov), .ws_sys(ws_sys),
      .ws_bp(ws_bp), .ws_adel_ld(ws_adel_ld), .ws_ades_st(ws_ades_st),
      .ws_data_addr(ws_data_addr), .ws_eret(ws_eret), .has_int(has_int),
      .c0_epc(c0_epc), .redirect_ready(redirect_ready), .ws_ready_go(ws_ready_go),
      .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
      .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   function automatic exp_t mk(input logic ex, input logic eret, input logic [4:0] code,
                               input logic bd, input logic [31:0] pc,
                               input logic [31:0] bva, input logic [31:0] rpc);
      exp_t e;
      e.ex = ex; e.eret = eret; e.excode = code; e.bd = bd;
      e.pc = pc; e.bva = bva; e.rpc = rpc;
      return e;
   endfunction

   task automatic clear_ws();
      ws_valid = 0; ws_bd = 0; ws_adel_if = 0; ws_ri = 0; ws_ov = 0; ws_sys = 0;
      ws_bp = 0; ws_adel_ld = 0; ws_ades_st = 0; ws_eret = 0; has_int = 0;
      ws_pc = '0; ws_data_addr = '0;
   endtask

   // Called #1 after a rising edge with the event inputs already driven.
   task automatic fire(input exp_t e);
      sb_q.push_back(e);
      #1;
      checks++;
      if (ws_ready_go !== 1'b0) begin
         errors++; $display("FAIL ready_go_accept: got %b want 0", ws_ready_go);
      end
      @(posedge clk); #1;
      clear_ws();
   endtask

   // Called at T+1; consumes one queued record and walks DRAIN/REDIRECT to IDLE.
   task automatic retire(input int ready_delay, input bit inject);
      exp_t e;
      int   drain;
      int   guard;
      logic [31:0] rpc_hold;
      if (sb_q.size() == 0) begin
         errors++; $display("FAIL scoreboard_empty: got 0 entries want 1");
         return;
      end
      e = sb_q.pop_front();
      checks++;
      if ({wb_ex, eret_flush} !== {e.ex, e.eret}) begin
         errors++; $display("FAIL pulse_kind: got ex=%b eret=%b want ex=%b eret=%b",
                            wb_ex, eret_flush, e.ex, e.eret);
      end
      if (e.ex) begin
         checks++;
         if (wb_excode !== e.excode) begin
            errors++; $display("FAIL excode: got %h want %h", wb_excode, e.excode);
         end
         checks++;
         if (wb_bd !== e.bd || wb_pc !== e.pc) begin
            errors++; $display("FAIL bd_pc: got %b/%h want %b/%h", wb_bd, wb_pc, e.bd, e.pc);
         end
         checks++;
         if (wb_badvaddr !== e.bva) begin
            errors++; $display("FAIL badvaddr: got %h want %h", wb_badvaddr, e.bva);
         end
      end
      checks++;
      if (flush !== 1'b1 || ws_ready_go !== 1'b0) begin
         errors++; $display("FAIL flush_t1: got flush=%b rg=%b want 1/0", flush, ws_ready_go);
      end
      drain = 1;
      @(posedge clk); #1;
      if (inject) begin
         ws_valid = 1; ws_bp = 1; ws_pc = 32'hbfc00abc;
         #1;
      end
      checks++;
      if (wb_ex !== 1'b0 || eret_flush !== 1'b0) begin
         errors++; $display("FAIL pulse_width: got ex=%b eret=%b want 0/0", wb_ex, eret_flush);
      end
      guard = 0;
      while (redirect_valid !== 1'b1 && guard < 20) begin
         if (flush === 1'b1) drain++;
         @(posedge clk); #2;
         guard++;
      end
      checks++;
      if (redirect_valid !== 1'b1) begin
         errors++; $display("FAIL redirect_timeout: got rv=%b want 1", redirect_valid);
      end
      checks++;
      if (drain != 2) begin
         errors++; $display("FAIL drain_cycles: got %0d want 2", drain);
      end
      checks++;
      if (redirect_pc !== e.rpc || flush !== 1'b1) begin
         errors++; $display("FAIL redirect_pc: got %h flush=%b want %h flush=1",
                            redirect_pc, flush, e.rpc);
      end
      rpc_hold = redirect_pc;
      for (int i = 0; i < ready_delay; i++) begin
         @(posedge clk); #2;
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== rpc_hold || flush !== 1'b1) begin
            errors++; $display("FAIL redirect_hold: got rv=%b pc=%h flush=%b want 1/%h/1",
                               redirect_valid, redirect_pc, flush, rpc_hold);
         end
      end
      if (inject) begin
         checks++;
         if (wb_ex !== 1'b0 || ws_ready_go !== 1'b0) begin
            errors++; $display("FAIL ignored_input: got ex=%b rg=%b want 0/0", wb_ex, ws_ready_go);
         end
      end
      redirect_ready = 1;
      @(posedge clk); #1;
      redirect_ready = 0;
      clear_ws();
      #1;
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || ws_ready_go !== 1'b1 || wb_ex !== 1'b0) begin
         errors++; $display("FAIL back_to_idle: got rv=%b flush=%b rg=%b ex=%b want 0/0/1/0",
                            redirect_valid, flush, ws_ready_go, wb_ex);
      end
   endtask

   task automatic test_reset();
      reset = 1; redirect_ready = 0; c0_epc = '0;
      clear_ws();
      #2;
      checks++;
      if ({wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush,
           redirect_valid, redirect_pc} !== '0 || ws_ready_go !== 1'b1) begin
         errors++; $display("FAIL reset_state: got ex=%b fl=%b rv=%b rg=%b want 0/0/0/1",
                            wb_ex, flush, redirect_valid, ws_ready_go);
      end
      @(negedge clk); reset = 0;
   endtask

   task automatic test_overflow();
      @(posedge clk); #1;
      ws_valid = 1; ws_ov = 1; ws_pc = 32'hbfc00100;
      fire(mk(1, 0, 5'h0c, 0, 32'hbfc00100, 32'h0, VEC));
      retire(0, 0);
   endtask

   task automatic test_priority();
      @(posedge clk); #1;
      ws_valid = 1; ws_adel_ld = 1; ws_ri = 1; ws_data_addr = 32'h1003; ws_pc = 32'hbfc00200;
      fire(mk(1, 0, 5'h0a, 0, 32'hbfc00200, 32'h0, VEC));
      retire(0, 0);
      @(posedge clk); #1;
      ws_valid = 1; ws_adel_ld = 1; ws_data_addr = 32'h1003; ws_pc = 32'hbfc00204;
      fire(mk(1, 0, 5'h04, 0, 32'hbfc00204, 32'h00001003, VEC));
      retire(0, 0);
      @(posedge clk); #1;
      ws_valid = 1; ws_adel_if = 1; ws_sys = 1; ws_pc = 32'hbfc00002;
      fire(mk(1, 0, 5'h04, 0, 32'hbfc00002, 32'hbfc00002, VEC));
      retire(0, 0);
      @(posedge clk); #1;
      ws_valid = 1; ws_ades_st = 1; ws_data_addr = 32'h2006; ws_pc = 32'hbfc00300;
      fire(mk(1, 0, 5'h05, 0, 32'hbfc00300, 32'h00002006, VEC));
      retire(0, 0);
   endtask

   task automatic test_eret();
      c0_epc = 32'hbfc01234;
      @(posedge clk); #1;
      ws_valid = 1; ws_eret = 1; ws_pc = 32'hbfc00400;
      fire(mk(0, 1, 5'h00, 0, 32'h0, 32'h0, 32'hbfc01234));
      retire(0, 0);
      @(posedge clk); #1;
      ws_valid = 1; ws_eret = 1; ws_sys = 1; ws_pc = 32'hbfc00404;
      fire(mk(1, 0, 5'h08, 0, 32'hbfc00404, 32'h0, VEC));
      retire(0, 0);
      @(posedge clk); #1;
      ws_valid = 1; ws_eret = 1; has_int = 1; ws_pc = 32'hbfc00408;
      fire(mk(1, 0, 5'h00, 0, 32'hbfc00408, 32'h0, VEC));
      retire(0, 0);
   endtask

   task automatic test_int_wait();
      @(posedge clk); #1;
      has_int = 1; ws_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (wb_ex !== 1'b0 || flush !== 1'b0 || ws_ready_go !== 1'b1) begin
            errors++; $display("FAIL int_no_valid: got ex=%b flush=%b rg=%b want 0/0/1",
                               wb_ex, flush, ws_ready_go);
         end
      end
      ws_valid = 1; ws_bd = 1; ws_pc = 32'hbfc00500;
      fire(mk(1, 0, 5'h00, 1, 32'hbfc00500, 32'h0, VEC));
      retire(2, 1);
   endtask

   task automatic test_stall_and_reset();
      exp_t e;
      int   guard;
      logic [31:0] rpc_hold;
      @(posedge clk); #1;
      ws_valid = 1; ws_bp = 1; ws_pc = 32'hbfc00600;
      fire(mk(1, 0, 5'h09, 0, 32'hbfc00600, 32'h0, VEC));
      e = sb_q.pop_front();
      checks++;
      if (wb_ex !== 1'b1 || wb_excode !== e.excode) begin
         errors++; $display("FAIL bp_pulse: got ex=%b code=%h want 1/%h", wb_ex, wb_excode, e.excode);
      end
      guard = 0;
      while (redirect_valid !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      rpc_hold = redirect_pc;
      checks++;
      if (redirect_valid !== 1'b1 || rpc_hold !== e.rpc) begin
         errors++; $display("FAIL stall_redirect: got rv=%b pc=%h want 1/%h",
                            redirect_valid, rpc_hold, e.rpc);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== rpc_hold || flush !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got rv=%b pc=%h flush=%b want 1/%h/1",
                               redirect_valid, redirect_pc, flush, rpc_hold);
         end
      end
      #2;
      reset = 1;
      #1;
      checks++;
      if ({wb_ex, eret_flush, wb_excode, wb_bd, wb_pc, wb_badvaddr, flush,
           redirect_valid, redirect_pc} !== '0 || ws_ready_go !== 1'b1) begin
         errors++; $display("FAIL reset_mid_redirect: got rv=%b fl=%b pc=%h rg=%b want 0/0/0/1",
                            redirect_valid, flush, redirect_pc, ws_ready_go);
      end
      @(negedge clk); reset = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (wb_ex !== 1'b0 || eret_flush !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL no_replay: got ex=%b eret=%b flush=%b want 0/0/0",
                               wb_ex, eret_flush, flush);
         end
      end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_priority();
      test_eret();
      test_int_wait();
      test_stall_and_reset();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
